squeeze_weight_sequencer: RTL and testbench

Address and handshake controller for the squeeze-layer weight/bias ROM bank, which serves 8 filter lanes × 16 channels per access. For a selected fire layer, it walks every output pixel, 8-filter group and 16-channel block. For each beat it drives the 8 weight base addresses, the 8 filter (bias) addresses and the layer select to the ROM. It sequences the squeeze MAC array through a valid/ready handshake and flags the first and last channel block so the MAC can clear its accumulators and add bias.

---
 rtl/sqz_pkg.sv | 39 +++
 rtl/squeeze_weight_sequencer_if.sv | 25 ++
 rtl/sqz_lane_addr_gen.sv | 82 ++++++++
 rtl/squeeze_weight_sequencer.sv | 124 ++++++++++++
 tb/tb_squeeze_weight_sequencer.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/sqz_pkg.sv
// Shared definitions for the squeeze-layer weight sequencer.
// Latency: n/a (types, constants and layer-shape lookups only).
// Backpressure: n/a.
package sqz_pkg;

  localparam int LANES  = 8;   // filter lanes per beat, one per ROM port
  localparam int CH_PAR = 16;  // channels per beat
  localparam int AW     = 32;  // ROM address width on the bus
  localparam int PIXW   = 16;  // pixel counter width
  localparam int IW     = 15;  // internal address width; the largest address is 32752

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Input channels of the selected fire layer.
  function automatic logic [9:0] cin_of(input logic [2:0] fs);
    case (fs)
      3'd0:       return 10'd64;
      3'd1, 3'd2: return 10'd128;
      3'd3, 3'd4: return 10'd256;
      3'd5, 3'd6: return 10'd384;
      default:    return 10'd512;
    endcase
  endfunction

  // Squeeze output filters of the selected fire layer.
  function automatic logic [6:0] cout_of(input logic [2:0] fs);
    case (fs)
      3'd0, 3'd1: return 7'd16;
      3'd2, 3'd3: return 7'd32;
      3'd4, 3'd5: return 7'd48;
      default:    return 7'd64;
    endcase
  endfunction

endpackage

// File: rtl/squeeze_weight_sequencer_if.sv
// Beat bus between the sequencer and the weight ROM / squeeze MAC array.
// Latency: n/a (wires only). master = sequencer, slave = ROM + MAC side.
// Backpressure: beat_ready from the MAC holds the current beat when low.
interface squeeze_weight_sequencer_if;
  import sqz_pkg::*;

  logic [2:0]          firesel;     // layer select to the ROM
  logic [LANES*AW-1:0] addr_w;      // lane k weight base at [k*AW+:AW]
  logic [LANES*AW-1:0] addr_filt;   // lane k filter/bias index at [k*AW+:AW]
  logic                beat_valid;
  logic                beat_ready;
  logic                first_blk;   // channel block 0: clear accumulators
  logic                last_blk;    // final channel block: add bias, emit

  modport master (
    output firesel, addr_w, addr_filt, beat_valid, first_blk, last_blk,
    input  beat_ready
  );

  modport slave (
    input  firesel, addr_w, addr_filt, beat_valid, first_blk, last_blk,
    output beat_ready
  );

endinterface

// File: rtl/sqz_lane_addr_gen.sv
// Incremental address generator for the 8 ROM lanes (no multipliers).
// Latency: strobes update registers; addresses appear the next cycle.
// Backpressure: registers only move on adv, so a stalled beat holds.
// Ports: load/adv/blk_wrap/grp_wrap strobes and cin from the FSM, run gates
// the outputs to zero outside a layer, addr_w/addr_filt are the lane buses.
module sqz_lane_addr_gen
  import sqz_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                adv,
  input  logic                blk_wrap,
  input  logic                grp_wrap,
  input  logic                run,
  input  logic [9:0]          cin,
  output logic [LANES*AW-1:0] addr_w,
  output logic [LANES*AW-1:0] addr_filt
);

  // lane_q[k] = (grp*8+k)*CIN, blk_q = cb*16, filt_q = grp*8
  logic [IW-1:0] lane_q [LANES];
  logic [IW-1:0] lane_d [LANES];
  logic [IW-1:0] lane_init [LANES];
  logic [IW-1:0] blk_q, blk_d;
  logic [IW-1:0] filt_q, filt_d;
  logic [IW-1:0] grp_step;

  assign grp_step = IW'({cin, 3'b000});  // 8 filters further = 8*CIN

  // k*CIN built by repeated addition.
  always_comb begin
    logic [IW-1:0] acc;
    acc = '0;
    for (int k = 0; k < LANES; k++) begin
      lane_init[k] = acc;
      acc          = acc + IW'(cin);
    end
  end

  always_comb begin
    lane_d = lane_q;
    blk_d  = blk_q;
    filt_d = filt_q;
    if (load || (adv && blk_wrap && grp_wrap)) begin
      // New layer or next pixel: back to group 0, block 0.
      lane_d = lane_init;
      blk_d  = '0;
      filt_d = '0;
    end else if (adv && blk_wrap) begin
      for (int k = 0; k < LANES; k++) lane_d[k] = lane_q[k] + grp_step;
      blk_d  = '0;
      filt_d = filt_q + IW'(LANES);
    end else if (adv) begin
      blk_d  = blk_q + IW'(CH_PAR);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < LANES; k++) lane_q[k] <= '0;
      blk_q  <= '0;
      filt_q <= '0;
    end else begin
      lane_q <= lane_d;
      blk_q  <= blk_d;
      filt_q <= filt_d;
    end
  end

  always_comb begin
    addr_w    = '0;
    addr_filt = '0;
    if (run) begin
      for (int k = 0; k < LANES; k++) begin
        addr_w[k*AW +: AW]    = AW'(lane_q[k] + blk_q);
        addr_filt[k*AW +: AW] = AW'(filt_q + IW'(k));
      end
    end
  end

endmodule

// File: rtl/squeeze_weight_sequencer.sv
// Walks pixel x filter-group x channel-block for one fire layer, driving ROM addresses.
// Latency: first beat 1 cycle after start, then 1 beat/cycle; done 1 cycle after last accept.
// Backpressure: beat_ready low holds every beat output stable.
// Ports: start/firesel_in/num_pixels request a layer (sampled in IDLE only),
// busy/done report progress, beat_if carries addresses and the MAC handshake.
module squeeze_weight_sequencer
  import sqz_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      firesel_in,
  input  logic [PIXW-1:0] num_pixels,
  output logic            busy,
  output logic            done,
  squeeze_weight_sequencer_if.master beat_if
);

  state_e          state_q, state_d;
  logic [2:0]      fs_q, fs_d;
  logic [PIXW-1:0] npix_q, npix_d;
  logic [PIXW-1:0] pix_q, pix_d;
  logic [4:0]      cb_q, cb_d;
  logic [2:0]      grp_q, grp_d;
  logic            load, adv, blk_wrap, grp_wrap, run;
  logic [9:0]      cin_cur, cin_gen;
  logic [5:0]      nblk;
  logic [3:0]      ngrp;

  assign cin_cur  = cin_of(fs_q);
  assign nblk     = 6'(cin_cur >> 4);
  assign ngrp     = 4'(cout_of(fs_q) >> 3);
  assign blk_wrap = (cb_q == 5'(nblk - 6'd1));
  assign grp_wrap = (grp_q == 3'(ngrp - 4'd1));
  assign run      = (state_q == RUN);
  // At load the layer register is not yet written, so use the requested layer.
  assign cin_gen  = load ? cin_of(firesel_in) : cin_cur;

  always_comb begin
    state_d = state_q;
    fs_d    = fs_q;
    npix_d  = npix_q;
    pix_d   = pix_q;
    cb_d    = cb_q;
    grp_d   = grp_q;
    load    = 1'b0;
    adv     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          fs_d   = firesel_in;
          npix_d = num_pixels;
          pix_d  = '0;
          cb_d   = '0;
          grp_d  = '0;
          if (num_pixels != '0) begin
            state_d = RUN;
            load    = 1'b1;
          end else begin
            state_d = DONE;
          end
        end
      end
      RUN: begin
        if (beat_if.beat_ready) begin
          adv = 1'b1;
          if (!blk_wrap) begin
            cb_d = cb_q + 5'd1;
          end else begin
            cb_d = '0;
            if (!grp_wrap) begin
              grp_d = grp_q + 3'd1;
            end else begin
              grp_d = '0;
              if ((pix_q + PIXW'(1)) == npix_q) state_d = DONE;
              else                              pix_d   = pix_q + PIXW'(1);
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      fs_q    <= '0;
      npix_q  <= '0;
      pix_q   <= '0;
      cb_q    <= '0;
      grp_q   <= '0;
    end else begin
      state_q <= state_d;
      fs_q    <= fs_d;
      npix_q  <= npix_d;
      pix_q   <= pix_d;
      cb_q    <= cb_d;
      grp_q   <= grp_d;
    end
  end

  sqz_lane_addr_gen u_lane_addr_gen (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .adv       (adv),
    .blk_wrap  (blk_wrap),
    .grp_wrap  (grp_wrap),
    .run       (run),
    .cin       (cin_gen),
    .addr_w    (beat_if.addr_w),
    .addr_filt (beat_if.addr_filt)
  );

  assign beat_if.firesel    = fs_q;
  assign beat_if.beat_valid = run;
  assign beat_if.first_blk  = run && (cb_q == 5'd0);
  assign beat_if.last_blk   = run && blk_wrap;
  assign busy               = run;
  assign done               = (state_q == DONE);

endmodule

// File: tb/tb_squeeze_weight_sequencer.sv
module tb_squeeze_weight_sequencer;
  import sqz_pkg::*;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic [2:0]      firesel_in = '0;
  logic [PIXW-1:0] num_pixels = '0;
  logic            busy, done;

  squeeze_weight_sequencer_if bif ();

  squeeze_weight_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .firesel_in (firesel_in),
    .num_pixels (num_pixels),
    .busy       (busy),
    .done       (done),
    .beat_if    (bif.master)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cin_t  [8] = '{64, 128, 128, 256, 256, 384, 384, 512};
  int cout_t [8] = '{16, 16, 32, 32, 48, 48, 64, 64};

  task automatic check(input string tag, input logic [LANES*AW-1:0] obs,
                       input logic [LANES*AW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, 256'(bif.beat_valid), 256'(0));
    check({tag, "_first"}, 256'(bif.first_blk), 256'(0));
    check({tag, "_last"},  256'(bif.last_blk), 256'(0));
    check({tag, "_busy"},  256'(busy), 256'(0));
    check({tag, "_done"},  256'(done), 256'(0));
    check({tag, "_addrw"}, bif.addr_w, 256'(0));
    check({tag, "_addrf"}, bif.addr_filt, 256'(0));
  endtask

  // rmode: 0 ready always, 1 ready 1010..., 2 random ready.
  // inject: pulse a start for layer 5 mid-run. abort_at: beat index to reset at (-1 none).
  task automatic run_layer(input int fs, input int np, input int rmode,
                           input bit inject, input int abort_at);
    int cin, ngrp, nblk, nb, idx, cyc, cb, grp, budget;
    bit injected;
    logic [LANES*AW-1:0] ew, ef;
    cin  = cin_t[fs];
    nblk = cin / 16;
    ngrp = cout_t[fs] / 8;
    nb   = np * ngrp * nblk;
    budget = nb * 4 + 50;
    idx = 0; cyc = 0; injected = 0;

    @(negedge clk);
    start = 1'b1; firesel_in = 3'(fs); num_pixels = PIXW'(np);
    bif.beat_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;

    if (np == 0) begin
      check("zero_done",  256'(done), 256'(1));
      check("zero_valid", 256'(bif.beat_valid), 256'(0));
      check("zero_busy",  256'(busy), 256'(0));
      @(negedge clk);
      check("zero_done_end", 256'(done), 256'(0));
      check("zero_busy_end", 256'(busy), 256'(0));
      check("zero_valid_end", 256'(bif.beat_valid), 256'(0));
      return;
    end

    forever begin
      start = 1'b0;
      if (cyc > budget) begin
        check("beat_timeout", 256'(idx), 256'(nb));
        return;
      end
      if (idx == abort_at) begin
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        check("abort_firesel", 256'(bif.firesel), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        check("abort_no_done", 256'(done), 256'(0));
        @(negedge clk);
        check_idle_outputs("after_abort");
        return;
      end
      cb  = idx % nblk;
      grp = (idx / nblk) % ngrp;
      for (int k = 0; k < LANES; k++) begin
        ew[k*AW +: AW] = AW'((grp * 8 + k) * cin + cb * 16);
        ef[k*AW +: AW] = AW'(grp * 8 + k);
      end
      check("valid",   256'(bif.beat_valid), 256'(1));
      check("busy",    256'(busy), 256'(1));
      check("done_run", 256'(done), 256'(0));
      check("firesel", 256'(bif.firesel), 256'(fs));
      check("addr_w",  bif.addr_w, ew);
      check("addr_filt", bif.addr_filt, ef);
      check("first_blk", 256'(bif.first_blk), 256'(cb == 0));
      check("last_blk",  256'(bif.last_blk), 256'(cb == nblk - 1));
      // Spot values worked out by hand for the smallest and largest layers.
      if (fs == 0 && idx == 0)
        check("f0_b0_lane7_w", 256'(bif.addr_w[7*AW +: AW]), 256'(448));
      if (fs == 0 && idx == 3)
        check("f0_b3_lane0_w", 256'(bif.addr_w[0 +: AW]), 256'(48));
      if (fs == 0 && idx == 4) begin
        check("f0_b4_lane0_w", 256'(bif.addr_w[0 +: AW]), 256'(512));
        check("f0_b4_lane0_f", 256'(bif.addr_filt[0 +: AW]), 256'(8));
      end
      if (fs == 7 && (idx == 255 || idx == 511)) begin
        check("f7_pixlast_lane7_w", 256'(bif.addr_w[7*AW +: AW]), 256'(32752));
        check("f7_pixlast_lane7_f", 256'(bif.addr_filt[7*AW +: AW]), 256'(63));
        check("f7_pixlast_last", 256'(bif.last_blk), 256'(1));
      end
      if (fs == 7 && idx == 256)
        check("f7_pix1_lane0_w", 256'(bif.addr_w[0 +: AW]), 256'(0));

      if (inject && !injected && idx == 5) begin
        start = 1'b1; firesel_in = 3'd5; num_pixels = PIXW'(7);
        injected = 1;
      end
      case (rmode)
        0:       bif.beat_ready = 1'b1;
        1:       bif.beat_ready = (cyc % 2 == 0);
        default: bif.beat_ready = 1'($urandom_range(0, 1));
      endcase
      if (bif.beat_ready) idx++;
      if (idx == nb) break;
      @(negedge clk);
      cyc++;
    end

    @(negedge clk);
    start = 1'b0;
    check("end_done",  256'(done), 256'(1));
    check("end_valid", 256'(bif.beat_valid), 256'(0));
    check("end_busy",  256'(busy), 256'(0));
    check("beat_count", 256'(idx), 256'(nb));
    @(negedge clk);
    check("end_done_pulse", 256'(done), 256'(0));
    check("end_idle_valid", 256'(bif.beat_valid), 256'(0));
  endtask

  initial begin
    bif.beat_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_idle_outputs("reset");
    check("reset_firesel", 256'(bif.firesel), 256'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    run_layer(0, 1, 0, 1'b0, -1);   // 8 back-to-back beats
    run_layer(7, 2, 0, 1'b0, -1);   // 512 beats, pixel rollover
    run_layer(2, 1, 1, 1'b0, -1);   // ready toggling
    run_layer(3, 0, 0, 1'b0, -1);   // zero pixels
    run_layer(1, 1, 0, 1'b1, -1);   // stray start mid-run
    run_layer(0, 1, 0, 1'b0, 3);    // reset at beat 3
    run_layer(0, 1, 0, 1'b0, -1);   // restart from lane0 address 0
    run_layer(6, 1, 2, 1'b0, 10);   // reset mid-layer on a nonzero layer
    for (int t = 0; t < 6; t++)
      run_layer(int'($urandom_range(0, 7)), int'($urandom_range(1, 3)), 2, 1'b0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
